// File: rtl/sensor_bus_pkg.sv
// sensor_bus_pkg: shared types and idle pin levels for the sensor bus arbiter
package sensor_bus_pkg;
    typedef enum logic [1:0] {IDLE, GUARD_IN, GRANT, GUARD_OUT} state_t;
    typedef enum logic [1:0] {OWN_NONE = 2'b00, OWN_SPI = 2'b01, OWN_I2C = 2'b10} owner_t;
    typedef struct packed {
        logic sclk;
        logic cs_n;
        logic oe;
        logic out;
    } pins_t;
    localparam pins_t PINS_IDLE = '{sclk: 1'b1, cs_n: 1'b1, oe: 1'b0, out: 1'b1};
endpackage

// File: rtl/sba_down_counter.sv
// sba_down_counter: loadable down counter that saturates at zero and flags it
module sba_down_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic         zero
);
    logic [W-1:0] cnt;
    assign zero = (cnt == '0);
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) cnt <= '0;
        else if (load) cnt <= load_val;
        else if (en && !zero) cnt <= cnt - 1'b1;
endmodule

// File: rtl/sensor_bus_arbiter.sv
// sensor_bus_arbiter: round-robin, guarded, hold-limited sharing of the sensor pins between SPI and I2C
module sensor_bus_arbiter
    import sensor_bus_pkg::*;
#(
    parameter int GUARD_CYCLES = 50,
    parameter int MAX_HOLD     = 5000000,
    parameter int HOLD_W       = 23
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       spi_req,
    output logic       spi_gnt,
    input  logic       spi_cs_n,
    input  logic       spi_sclk,
    input  logic       spi_sdo,
    input  logic       spi_sdo_oe,
    output logic       spi_sdi,
    input  logic       i2c_req,
    output logic       i2c_gnt,
    input  logic       i2c_scl,
    input  logic       i2c_sda_low,
    output logic       i2c_sda_in,
    output logic       bus_sclk,
    output logic       bus_cs_n,
    output logic       bus_sdat_oe,
    output logic       bus_sdat_out,
    input  logic       bus_sdat_in,
    input  logic       timeout_clr,
    output logic       timeout_flag,
    output logic [1:0] owner
);
    localparam int GW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;

    state_t            state;
    owner_t            win, last;
    pins_t             pins, grant_pins;
    logic [HOLD_W-1:0] hold;
    logic              spi_mask, i2c_mask, spi_av, i2c_av, pick_spi, win_req;
    logic              hold_last, hold_on, g_load, g_en, g_zero;

    assign spi_av    = spi_req && !spi_mask;
    assign i2c_av    = i2c_req && !i2c_mask;
    assign pick_spi  = spi_av && (!i2c_av || last == OWN_I2C);
    assign win_req   = (win == OWN_SPI) ? spi_req : i2c_req;
    assign hold_last = (hold == HOLD_W'(MAX_HOLD - 1));
    // hold_on: the bus is owned during the coming cycle, so pins/grants follow the winner
    assign hold_on   = win_req && ((state == GUARD_IN && g_zero) || (state == GRANT && !hold_last));
    assign g_load    = (state == IDLE && (spi_av || i2c_av)) ||
                       (state == GUARD_IN && !win_req) ||
                       (state == GRANT && (!win_req || hold_last));
    assign g_en      = (state == GUARD_IN) || (state == GUARD_OUT);

    always_comb
        grant_pins = (win == OWN_SPI) ? {spi_sclk, spi_cs_n, spi_sdo_oe, spi_sdo}
                                      : {i2c_scl, 1'b1, i2c_sda_low, 1'b0};

    sba_down_counter #(.W(GW)) u_guard (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (g_load),
        .en       (g_en),
        .load_val (GW'(GUARD_CYCLES - 1)),
        .zero     (g_zero)
    );

    assign bus_sclk     = pins.sclk;
    assign bus_cs_n     = pins.cs_n;
    assign bus_sdat_oe  = pins.oe;
    assign bus_sdat_out = pins.out;

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            state        <= IDLE;
            win          <= OWN_NONE;
            last         <= OWN_I2C;
            hold         <= '0;
            spi_mask     <= 1'b0;
            i2c_mask     <= 1'b0;
            spi_gnt      <= 1'b0;
            i2c_gnt      <= 1'b0;
            owner        <= OWN_NONE;
            pins         <= PINS_IDLE;
            spi_sdi      <= 1'b1;
            i2c_sda_in   <= 1'b1;
            timeout_flag <= 1'b0;
        end else begin
            spi_gnt    <= hold_on && win == OWN_SPI;
            i2c_gnt    <= hold_on && win == OWN_I2C;
            owner      <= hold_on ? win : OWN_NONE;
            pins       <= hold_on ? grant_pins : PINS_IDLE;
            spi_sdi    <= (hold_on && win == OWN_SPI) ? bus_sdat_in : 1'b1;
            i2c_sda_in <= (hold_on && win == OWN_I2C) ? bus_sdat_in : 1'b1;
            if (!spi_req) spi_mask <= 1'b0;
            if (!i2c_req) i2c_mask <= 1'b0;
            if (timeout_clr) timeout_flag <= 1'b0;
            case (state)
                IDLE:
                    if (spi_av || i2c_av) begin
                        win   <= pick_spi ? OWN_SPI : OWN_I2C;
                        state <= GUARD_IN;
                    end
                GUARD_IN:
                    if (!win_req) state <= GUARD_OUT;
                    else if (g_zero) begin
                        state <= GRANT;
                        hold  <= '0;
                    end
                GRANT:
                    if (!win_req) state <= GUARD_OUT;
                    else if (hold_last) begin
                        state        <= GUARD_OUT;
                        timeout_flag <= 1'b1;
                        if (win == OWN_SPI) spi_mask <= 1'b1;
                        else i2c_mask <= 1'b1;
                    end else hold <= hold + 1'b1;
                GUARD_OUT:
                    if (g_zero) begin
                        state <= IDLE;
                        last  <= win;
                    end
                default: state <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_sensor_bus_arbiter.sv
// tb_sensor_bus_arbiter: directed checks of grant timing, fairness, timeout and reset
module tb_sensor_bus_arbiter;
    logic       clk = 1'b0, reset_n = 1'b0;
    logic       spi_req = 0, spi_cs_n = 1, spi_sclk = 1, spi_sdo = 1, spi_sdo_oe = 0;
    logic       i2c_req = 0, i2c_scl = 1, i2c_sda_low = 0, bus_sdat_in = 1, timeout_clr = 0;
    logic       spi_gnt, spi_sdi, i2c_gnt, i2c_sda_in;
    logic       bus_sclk, bus_cs_n, bus_sdat_oe, bus_sdat_out, timeout_flag;
    logic [1:0] owner;
    int         passed = 0, total = 0;

    sensor_bus_arbiter #(.GUARD_CYCLES(4), .MAX_HOLD(20), .HOLD_W(5)) dut (
        .clk(clk), .reset_n(reset_n),
        .spi_req(spi_req), .spi_gnt(spi_gnt), .spi_cs_n(spi_cs_n), .spi_sclk(spi_sclk),
        .spi_sdo(spi_sdo), .spi_sdo_oe(spi_sdo_oe), .spi_sdi(spi_sdi),
        .i2c_req(i2c_req), .i2c_gnt(i2c_gnt), .i2c_scl(i2c_scl), .i2c_sda_low(i2c_sda_low),
        .i2c_sda_in(i2c_sda_in),
        .bus_sclk(bus_sclk), .bus_cs_n(bus_cs_n), .bus_sdat_oe(bus_sdat_oe),
        .bus_sdat_out(bus_sdat_out), .bus_sdat_in(bus_sdat_in),
        .timeout_clr(timeout_clr), .timeout_flag(timeout_flag), .owner(owner)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [10:0] outs();
        return {spi_gnt, i2c_gnt, owner, bus_sclk, bus_cs_n, bus_sdat_oe, bus_sdat_out,
                spi_sdi, i2c_sda_in, timeout_flag};
    endfunction

    function automatic logic [3:0] pins();
        return {bus_sclk, bus_cs_n, bus_sdat_oe, bus_sdat_out};
    endfunction

    initial begin
        #12;
        check("reset_outs", outs(), 11'b0_0_00_1_1_0_1_1_1_0);
        @(negedge clk) reset_n = 1;
        bus_sdat_in = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            check("idle_pins", pins(), 4'b1101);
        end
        check("idle_sdi", {spi_sdi, i2c_sda_in}, 2'b11);
        bus_sdat_in = 1;

        spi_req = 1; spi_cs_n = 0;
        tick(4);
        check("spi_gnt_early", spi_gnt, 0);
        tick(1);
        check("spi_gnt", spi_gnt, 1);
        check("spi_owner", owner, 2'b01);
        check("spi_pins0", pins(), 4'b1001);
        spi_sclk = 0; spi_sdo_oe = 1; spi_sdo = 0; bus_sdat_in = 0;
        tick(1);
        check("spi_pins1", pins(), 4'b0010);
        check("spi_readback", {spi_sdi, i2c_sda_in}, 2'b01);
        spi_req = 0;
        tick(1);
        check("spi_release", outs(), 11'b0_0_00_1_1_0_1_1_1_0);
        spi_sclk = 1; spi_cs_n = 1; spi_sdo_oe = 0; spi_sdo = 1; bus_sdat_in = 1;
        tick(6);

        reset_n = 0;
        @(negedge clk) reset_n = 1;
        tick(1);
        spi_req = 1; i2c_req = 1;
        tick(5);
        check("rr_first", {spi_gnt, i2c_gnt}, 2'b10);
        tick(3);
        check("rr_hold", owner, 2'b01);
        spi_req = 0;
        tick(1);
        check("rr_drop", {spi_gnt, i2c_gnt}, 2'b00);
        tick(8);
        check("rr_wait", i2c_gnt, 0);
        tick(1);
        check("rr_i2c_gnt", i2c_gnt, 1);
        check("rr_i2c_owner", owner, 2'b10);
        check("i2c_pins0", pins(), 4'b1100);
        i2c_scl = 0; i2c_sda_low = 1; bus_sdat_in = 0;
        tick(1);
        check("i2c_pins1", pins(), 4'b0110);
        check("i2c_readback", {spi_sdi, i2c_sda_in}, 2'b10);
        i2c_scl = 1; i2c_sda_low = 0; bus_sdat_in = 1;

        tick(18);
        check("to_before", {i2c_gnt, timeout_flag}, 2'b10);
        tick(1);
        check("to_fire", {i2c_gnt, timeout_flag, owner}, 4'b0100);
        tick(20);
        check("to_masked", {i2c_gnt, owner}, 3'b000);
        i2c_req = 0;
        tick(1);
        i2c_req = 1;
        tick(4);
        check("rereq_wait", i2c_gnt, 0);
        tick(1);
        check("rereq_gnt", i2c_gnt, 1);
        check("flag_sticky", timeout_flag, 1);
        timeout_clr = 1;
        tick(1);
        check("flag_clr", timeout_flag, 0);
        timeout_clr = 0;
        tick(18);
        timeout_clr = 1;
        tick(1);
        check("set_wins", {i2c_gnt, timeout_flag}, 2'b01);
        timeout_clr = 0;
        tick(1);
        check("flag_hold", timeout_flag, 1);
        timeout_clr = 1;
        tick(1);
        check("flag_clr2", timeout_flag, 0);
        timeout_clr = 0; i2c_req = 0;
        tick(8);

        spi_req = 1; spi_cs_n = 0;
        tick(5);
        check("pre_rst", {spi_gnt, bus_cs_n}, 2'b10);
        #2 reset_n = 0;
        #1;
        check("async_rst", {spi_gnt, bus_cs_n}, 2'b01);
        check("async_outs", outs(), 11'b0_0_00_1_1_0_1_1_1_0);
        spi_req = 0; spi_cs_n = 1;
        @(negedge clk) reset_n = 1;
        tick(3);
        check("post_rst", outs(), 11'b0_0_00_1_1_0_1_1_1_0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
